sound_psg_env: RTL and testbench

SOUND_PSG_ENV -- requirements
Module: sound_psg_env

---
 rtl/sound_psg_env.sv | 198 +++++++++++++++++++
 tb/tb_sound_psg_env.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sound_psg_env.sv
// Programmable sound generator: square/noise tone voices with volume envelopes,
// mixed on every prescaler tick into a saturated, registered output sample.
module sound_psg_env #(
  parameter int NVOICES     = 4,
  parameter int PERIOD_BITS = 12,
  parameter int VOL_BITS    = 4,
  parameter int OUT_BITS    = 8,
  parameter int PRESCALE    = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          reg_sel,
  input  logic [7:0]          reg_data,
  input  logic                reg_write,
  output logic [OUT_BITS-1:0] out,
  output logic                sample_strobe
);

  localparam int          PRE_BITS  = $clog2(PRESCALE);
  localparam int          SUM_MAX   = NVOICES * ((1 << VOL_BITS) - 1);
  localparam int          SUM_BITS  = $clog2(SUM_MAX + 1);
  localparam longint      OUT_MAX   = (64'd1 << OUT_BITS) - 1;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [PRE_BITS-1:0]    presc_q, presc_d;
  logic [PERIOD_BITS-1:0] period_q [NVOICES];
  logic [PERIOD_BITS-1:0] period_d [NVOICES];
  logic [PERIOD_BITS-1:0] cnt_q [NVOICES];
  logic [PERIOD_BITS-1:0] cnt_d [NVOICES];
  logic [VOL_BITS-1:0]    volume_q [NVOICES];
  logic [VOL_BITS-1:0]    volume_d [NVOICES];
  logic [VOL_BITS-1:0]    level_q [NVOICES];
  logic [VOL_BITS-1:0]    level_d [NVOICES];
  logic [7:0]             env_rate_q [NVOICES];
  logic [7:0]             env_rate_d [NVOICES];
  logic [7:0]             rate_cnt_q [NVOICES];
  logic [7:0]             rate_cnt_d [NVOICES];
  logic [NVOICES-1:0]     square_q, square_d;
  logic [NVOICES-1:0]     noise_sel_q, noise_sel_d;
  logic [NVOICES-1:0]     env_en_q, env_en_d;
  logic [NVOICES-1:0]     env_up_q, env_up_d;
  logic [NVOICES-1:0]     mask_q, mask_d;
  logic [7:0]             noise_per_q, noise_per_d;
  logic [7:0]             noise_cnt_q, noise_cnt_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [OUT_BITS-1:0]    out_q, out_d;
  logic                   strobe_q, strobe_d;

  logic                   tick;
  logic [2:0]             wr_voice;
  logic [1:0]             wr_field;
  logic [NVOICES-1:0]     wave;
  logic [SUM_BITS-1:0]    sum;

  assign tick          = (presc_q == PRE_BITS'(PRESCALE - 1));
  assign wr_voice      = reg_sel[4:2];
  assign wr_field      = reg_sel[1:0];
  assign out           = out_q;
  assign sample_strobe = strobe_q;

  always_comb begin
    wave = '0;
    sum  = '0;
    for (int v = 0; v < NVOICES; v++) begin
      wave[v] = noise_sel_q[v] ? lfsr_q[0] : square_q[v];
      if (mask_q[v] && wave[v]) sum = sum + SUM_BITS'(level_q[v]);
    end
  end

  // Tick updates run on pre-write state; a coincident write then overrides,
  // so an envelope restart wins over a same-edge envelope step.
  always_comb begin
    presc_d     = tick ? '0 : presc_q + PRE_BITS'(1);
    period_d    = period_q;
    cnt_d       = cnt_q;
    volume_d    = volume_q;
    level_d     = level_q;
    env_rate_d  = env_rate_q;
    rate_cnt_d  = rate_cnt_q;
    square_d    = square_q;
    noise_sel_d = noise_sel_q;
    env_en_d    = env_en_q;
    env_up_d    = env_up_q;
    mask_d      = mask_q;
    noise_per_d = noise_per_q;
    noise_cnt_d = noise_cnt_q;
    lfsr_d      = lfsr_q;
    out_d       = out_q;
    strobe_d    = tick;

    if (tick) begin
      if (64'(sum) > OUT_MAX) out_d = '1;
      else                    out_d = OUT_BITS'(sum);

      for (int v = 0; v < NVOICES; v++) begin
        if (period_q[v] == '0) begin
          square_d[v] = 1'b0;
          cnt_d[v]    = '0;
        end else if (cnt_q[v] >= period_q[v]) begin
          square_d[v] = ~square_q[v];
          cnt_d[v]    = '0;
        end else begin
          cnt_d[v] = cnt_q[v] + PERIOD_BITS'(1);
        end

        if (env_en_q[v]) begin
          if (rate_cnt_q[v] >= env_rate_q[v]) begin
            rate_cnt_d[v] = '0;
            if (env_up_q[v]) begin
              if (level_q[v] != '1) level_d[v] = level_q[v] + VOL_BITS'(1);
            end else begin
              if (level_q[v] != '0) level_d[v] = level_q[v] - VOL_BITS'(1);
            end
          end else begin
            rate_cnt_d[v] = rate_cnt_q[v] + 8'd1;
          end
        end
      end

      // Taps 16,14,13,11 shifting right; maximal length keeps it off all-zero.
      if (noise_cnt_q >= noise_per_q) begin
        lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        noise_cnt_d = '0;
      end else begin
        noise_cnt_d = noise_cnt_q + 8'd1;
      end
    end

    if (reg_write) begin
      for (int v = 0; v < NVOICES; v++) begin
        if (wr_voice == 3'(v)) begin
          case (wr_field)
            2'd0: period_d[v][7:0] = reg_data;
            2'd1: period_d[v][PERIOD_BITS-1:8] = reg_data[PERIOD_BITS-9:0];
            2'd2: begin
              noise_sel_d[v] = reg_data[7];
              env_en_d[v]    = reg_data[6];
              env_up_d[v]    = reg_data[5];
              volume_d[v]    = reg_data[VOL_BITS-1:0];
              level_d[v]     = reg_data[VOL_BITS-1:0];
              rate_cnt_d[v]  = '0;
            end
            default: env_rate_d[v] = reg_data;
          endcase
        end
      end
      if (wr_voice == 3'd7) begin
        if (wr_field == 2'd0) mask_d      = reg_data[NVOICES-1:0];
        if (wr_field == 2'd1) noise_per_d = reg_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q     <= '0;
      square_q    <= '0;
      noise_sel_q <= '0;
      env_en_q    <= '0;
      env_up_q    <= '0;
      mask_q      <= '0;
      noise_per_q <= '0;
      noise_cnt_q <= '0;
      lfsr_q      <= LFSR_SEED;
      out_q       <= '0;
      strobe_q    <= 1'b0;
      for (int v = 0; v < NVOICES; v++) begin
        period_q[v]   <= '0;
        cnt_q[v]      <= '0;
        volume_q[v]   <= '0;
        level_q[v]    <= '0;
        env_rate_q[v] <= '0;
        rate_cnt_q[v] <= '0;
      end
    end else begin
      presc_q     <= presc_d;
      square_q    <= square_d;
      noise_sel_q <= noise_sel_d;
      env_en_q    <= env_en_d;
      env_up_q    <= env_up_d;
      mask_q      <= mask_d;
      noise_per_q <= noise_per_d;
      noise_cnt_q <= noise_cnt_d;
      lfsr_q      <= lfsr_d;
      out_q       <= out_d;
      strobe_q    <= strobe_d;
      for (int v = 0; v < NVOICES; v++) begin
        period_q[v]   <= period_d[v];
        cnt_q[v]      <= cnt_d[v];
        volume_q[v]   <= volume_d[v];
        level_q[v]    <= level_d[v];
        env_rate_q[v] <= env_rate_d[v];
        rate_cnt_q[v] <= rate_cnt_d[v];
      end
    end
  end

endmodule

// File: tb/tb_sound_psg_env.sv
// Scoreboarded bench for sound_psg_env: a tick-level reference model pushes
// expected samples, a monitor pops them whenever the DUT strobes a sample.
module tb_sound_psg_env;

  localparam int NV = 4;
  localparam int PB = 12;
  localparam int VB = 4;
  localparam int OB = 5;
  localparam int PS = 4;
  localparam int VMAX = (1 << VB) - 1;
  localparam int OMAX = (1 << OB) - 1;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic [4:0]    regSel = '0;
  logic [7:0]    regData = '0;
  logic          regWrite = 1'b0;
  logic [OB-1:0] out;
  logic          sampleStrobe;

  int compared = 0;
  int mismatched = 0;
  int expQ[$];

  int mPresc, mMask, mNper, mNcnt, mLfsr;
  int mPeriod[NV], mCnt[NV], mSq[NV], mNoiseSel[NV], mEnvEn[NV], mEnvUp[NV];
  int mVol[NV], mRate[NV], mLevel[NV], mRcnt[NV];

  sound_psg_env #(
    .NVOICES(NV), .PERIOD_BITS(PB), .VOL_BITS(VB), .OUT_BITS(OB), .PRESCALE(PS)
  ) dut (
    .clk(clk), .reset(rstN), .reg_sel(regSel), .reg_data(regData),
    .reg_write(regWrite), .out(out), .sample_strobe(sampleStrobe)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int lfsrNext(input int l);
    int fb;
    fb = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return (l >> 1) | (fb << 15);
  endfunction

  task automatic modelReset();
    mPresc = 0; mMask = 0; mNper = 0; mNcnt = 0; mLfsr = 'hACE1;
    for (int v = 0; v < NV; v++) begin
      mPeriod[v] = 0; mCnt[v] = 0; mSq[v] = 0; mNoiseSel[v] = 0; mEnvEn[v] = 0;
      mEnvUp[v] = 0; mVol[v] = 0; mRate[v] = 0; mLevel[v] = 0; mRcnt[v] = 0;
    end
    expQ.delete();
  endtask

  // One clock of the reference: the tick sees pre-write state, then the write lands.
  task automatic modelStep();
    bit tick;
    int sum, wv, fld, d;
    if (!rstN) begin
      modelReset();
      return;
    end
    tick = (mPresc == PS - 1);
    mPresc = tick ? 0 : mPresc + 1;
    if (tick) begin
      sum = 0;
      for (int v = 0; v < NV; v++)
        if (((mMask >> v) & 1) == 1 && (mNoiseSel[v] != 0 ? (mLfsr & 1) : mSq[v]) == 1)
          sum += mLevel[v];
      expQ.push_back(sum > OMAX ? OMAX : sum);
      for (int v = 0; v < NV; v++) begin
        if (mPeriod[v] == 0) begin
          mSq[v] = 0; mCnt[v] = 0;
        end else if (mCnt[v] >= mPeriod[v]) begin
          mSq[v] = 1 - mSq[v]; mCnt[v] = 0;
        end else mCnt[v]++;
        if (mEnvEn[v] != 0) begin
          if (mRcnt[v] >= mRate[v]) begin
            mRcnt[v] = 0;
            if (mEnvUp[v] != 0) mLevel[v] = (mLevel[v] < VMAX) ? mLevel[v] + 1 : VMAX;
            else                mLevel[v] = (mLevel[v] > 0) ? mLevel[v] - 1 : 0;
          end else mRcnt[v]++;
        end
      end
      if (mNcnt >= mNper) begin
        mLfsr = lfsrNext(mLfsr); mNcnt = 0;
      end else mNcnt++;
    end
    if (regWrite) begin
      wv = int'(regSel[4:2]); fld = int'(regSel[1:0]); d = int'(regData);
      if (wv < NV) begin
        case (fld)
          0: mPeriod[wv] = (mPeriod[wv] & ~255) | d;
          1: mPeriod[wv] = (mPeriod[wv] & 255) | ((d & ((1 << (PB - 8)) - 1)) << 8);
          2: begin
            mNoiseSel[wv] = (d >> 7) & 1; mEnvEn[wv] = (d >> 6) & 1; mEnvUp[wv] = (d >> 5) & 1;
            mVol[wv] = d & VMAX; mLevel[wv] = mVol[wv]; mRcnt[wv] = 0;
          end
          default: mRate[wv] = d;
        endcase
      end else if (wv == 7) begin
        if (fld == 0) mMask = d & ((1 << NV) - 1);
        if (fld == 1) mNper = d;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (sampleStrobe || expQ.size() != 0) begin
      checkOutput("sample_strobe", int'(sampleStrobe), int'(expQ.size() != 0));
      if (expQ.size() != 0) begin
        if (sampleStrobe) checkOutput("out", int'(out), expQ.pop_front());
        else void'(expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [4:0] sel, input logic [7:0] data);
    @(negedge clk);
    regSel = sel; regData = data; regWrite = 1'b1;
    @(negedge clk);
    regWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset pulse with an ignored write while low and immediate-state checks.
  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("reset_out", int'(out), 0);
    checkOutput("reset_strobe", int'(sampleStrobe), 0);
    checkOutput("reset_lfsr", int'(dut.lfsr_q), 'hACE1);
    @(negedge clk);
    regSel = 5'd28; regData = 8'h0F; regWrite = 1'b1;
    @(negedge clk);
    regWrite = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    int wv, fld;
    logic [7:0] d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("init_out", int'(out), 0);
    checkOutput("init_strobe", int'(sampleStrobe), 0);
    checkOutput("init_lfsr", int'(dut.lfsr_q), 'hACE1);
    @(negedge clk) rstN = 1'b1;

    $display("[TB] square wave, period 3");
    applyStimulus(5'd0, 8'd3);
    applyStimulus(5'd2, 8'h0F);
    applyStimulus(5'd28, 8'h01);
    idle(80);

    $display("[TB] saturation with four full voices");
    doReset();
    for (int v = 0; v < NV; v++) applyStimulus(5'(v * 4 + 2), 8'h8F);
    applyStimulus(5'd28, 8'h0F);
    idle(100);

    $display("[TB] decaying envelope");
    doReset();
    applyStimulus(5'd3, 8'd1);
    applyStimulus(5'd0, 8'd1);
    applyStimulus(5'd2, 8'h43);
    applyStimulus(5'd28, 8'h01);
    idle(60);

    $display("[TB] period shrink below counter");
    doReset();
    applyStimulus(5'd0, 8'd20);
    applyStimulus(5'd2, 8'h0F);
    applyStimulus(5'd28, 8'h01);
    idle(38);
    applyStimulus(5'd0, 8'd2);
    idle(60);

    $display("[TB] noise every tick");
    doReset();
    applyStimulus(5'd2, 8'h8F);
    applyStimulus(5'd29, 8'd0);
    applyStimulus(5'd28, 8'h01);
    idle(6000);

    $display("[TB] reset mid-envelope");
    doReset();
    applyStimulus(5'd0, 8'd1);
    applyStimulus(5'd3, 8'd2);
    applyStimulus(5'd2, 8'h64);
    applyStimulus(5'd28, 8'h01);
    idle(30);
    doReset();
    idle(40);
    checkOutput("silent_after_reset", int'(out), 0);

    $display("[TB] randomized register traffic");
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) doReset();
      else if ($urandom_range(0, 2) == 0) begin
        wv = $urandom_range(0, 7);
        fld = $urandom_range(0, 3);
        d = 8'($urandom_range(0, 255));
        if (wv < NV && fld == 0) d = 8'($urandom_range(0, 9));
        if (wv < NV && fld == 1) d = ($urandom_range(0, 7) == 0) ? d : 8'd0;
        if (wv < NV && fld == 3) d = 8'($urandom_range(0, 3));
        if (wv == 7 && fld == 1) d = 8'($urandom_range(0, 5));
        applyStimulus(5'({wv[2:0], fld[1:0]}), d);
      end else idle(1);
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
